phase_sequencer: RTL and testbench
==================================

Name: phase_sequencer

Overview:
- 64-phase sequencer for the 8-band equalizer datapath.
- A 6-bit free-running phase counter advances once per enabled clock and wraps 63 -> 0.
- A combinational decoder flags the first phase (0) and last phase (63), and produces an active-low control-phase strobe.
- Downstream tap/accumulator logic uses these flags to start, finish and dump each 64-sample processing frame.

Parameters:
- COUNT_W, 6, width of the phase counter; number of phases is 2**COUNT_W.
- LAST_PHASE, 2**COUNT_W-1 (63), count value decoded as phase_63; fixed by COUNT_W and not separately overridable.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- clk_enable  input  1  count-enable / qualifier for the phase strobes.
- current_count  output  COUNT_W  registered phase counter value.
- phase_63  output  1  high while the count equals LAST_PHASE and clk_enable is high.
- phase_0  output  1  high while the count equals 0 and clk_enable is high.
- control_phase_bar  output  1  active-low control strobe; low exactly when phase_0 is high, otherwise high.

Behaviour:
- Counter update on rising clk edge:
  - rst=1: current_count <= 0, regardless of clk_enable.
  - else if clk_enable=1: current_count <= current_count + 1, modulo 2**COUNT_W (63 -> 0, no saturation).
  - else: current_count holds.
- Reset values: current_count=0.
  - phase_0 = clk_enable.
  - phase_63 = 0.
  - control_phase_bar = ~clk_enable.
- Decode outputs:
  - Purely combinational from current_count and clk_enable, with zero latency.
  - rst does not gate the decode outputs; they reflect the held count.
- phase_0 = clk_enable & (current_count == 0).
- phase_63 = clk_enable & (current_count == LAST_PHASE).
- control_phase_bar = ~phase_0.
- phase_0 and phase_63 are mutually exclusive.
  - With clk_enable held high, each is high for exactly 1 cycle in every 64.
  - phase_63 is immediately followed by phase_0 on the next cycle (wrap).
- clk_enable low forces phase_0 = 0, phase_63 = 0, control_phase_bar = 1, and freezes the count.
- Reset mid-count forces the count to 0 on the next edge.
  - After rst is released, the first enabled edge yields 1.
  - The count after k enabled post-reset edges is k mod 64.
- No X propagation: all outputs are defined from the first clock with rst asserted.

Decomposition:
- Shared package phase_seq_pkg holds:
  - localparam COUNT_W = 6.
  - localparam LAST_PHASE = 63.
  - typedef logic [COUNT_W-1:0] phase_t, used for current_count in the equalizer tap-index logic.
- Split into two pieces:
  - Top level phase_sequencer contains the counter register.
  - Sub-module phase_decode is stateless and holds the three combinational flags.
- phase_decode is reusable wherever a phase_t must be decoded.

Test Plan:
- Reset: rst=1, clk_enable=1 for 10 cycles -> current_count=0, phase_0=1, phase_63=0, control_phase_bar=0 throughout.
- Count run: release rst, hold clk_enable=1 for 100 cycles.
  - After edge 1: count=1, phase_0=0, control_phase_bar=1.
  - After edge 63: count=63, phase_63=1.
  - After edge 64: count=0, phase_0=1, control_phase_bar=0.
  - After edge 100: count=36.
- Mid-run reset: at count=36, assert rst for 6 cycles -> count=0 after the first reset edge and stays 0. Release rst and run 200 cycles:
  - count wraps 3 times (0 at edges 64, 128, 192; 8 at edge 200).
  - phase_63 pulses exactly 3 times, each 1 cycle wide, each followed by a phase_0 pulse.
- Enable gating: at count=10, drop clk_enable for 5 cycles -> count holds at 10, phase flags are 0, control_phase_bar=1.
  - Re-enable -> the next edge yields 11.
- Gating at boundaries:
  - Drop clk_enable while count=63 -> phase_63 falls to 0 immediately and count holds at 63; re-enable -> phase_63=1, then the next edge yields 0.
  - Drop clk_enable while count=0 -> phase_0=0 and control_phase_bar=1 immediately.

Source files
------------

// File: rtl/phase_sequencer_pkg.sv
// Shared phase-sequencer definitions for the 8-band equalizer datapath.
// Phase width, last-phase value and the phase index type used by tap logic.
package phase_seq_pkg;

    localparam int COUNT_W    = 6;
    localparam int LAST_PHASE = (1 << COUNT_W) - 1;

    typedef logic [COUNT_W-1:0] phase_t;

    // Next phase in a free-running frame, wrapping LAST_PHASE -> 0.
    function automatic phase_t next_phase(input phase_t cur);
        return cur + phase_t'(1);
    endfunction

endpackage

// File: rtl/phase_sequencer_if.sv
// Phase-sequencer bundle: count enable in, registered phase and frame flags out.
// master = sequencer side, slave = downstream tap/accumulator side.
interface phase_sequencer_if #(
    parameter int COUNT_W = phase_seq_pkg::COUNT_W
);
    logic               clk_enable;
    logic [COUNT_W-1:0] current_count;
    logic               phase_0;
    logic               phase_63;
    logic               control_phase_bar;

    modport master (
        input  clk_enable,
        output current_count,
        output phase_0,
        output phase_63,
        output control_phase_bar
    );

    modport slave (
        output clk_enable,
        input  current_count,
        input  phase_0,
        input  phase_63,
        input  control_phase_bar
    );
endinterface

// File: rtl/phase_sequencer_decode.sv
// Stateless frame-boundary decoder for a phase count; zero latency.
// No backpressure: flags follow the count and enable combinationally.
module phase_decode #(
    parameter int COUNT_W = phase_seq_pkg::COUNT_W
) (
    input  logic [COUNT_W-1:0] count,
    input  logic               enable,
    output logic               first_phase,
    output logic               last_phase,
    output logic               control_phase_bar
);
    localparam logic [COUNT_W-1:0] FIRST_VAL = '0;
    localparam logic [COUNT_W-1:0] LAST_VAL  = '1;

    always_comb begin
        first_phase       = enable & (count == FIRST_VAL);
        last_phase        = enable & (count == LAST_VAL);
        control_phase_bar = ~first_phase;
    end
endmodule

// File: rtl/phase_sequencer.sv
// Free-running 64-phase frame counter with first/last/control decode; count is registered.
// No backpressure: clk_enable low freezes the count and suppresses the strobes.
module phase_sequencer
    import phase_seq_pkg::*;
#(
    parameter int COUNT_W = phase_seq_pkg::COUNT_W
) (
    input  logic              clk,
    input  logic              rst,
    phase_sequencer_if.master seq
);
    logic [COUNT_W-1:0] count_q;

    // Reset wins over enable; the decode is deliberately left ungated by rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (seq.clk_enable) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign seq.current_count = count_q;

    phase_decode #(
        .COUNT_W (COUNT_W)
    ) u_decode (
        .count             (count_q),
        .enable            (seq.clk_enable),
        .first_phase       (seq.phase_0),
        .last_phase        (seq.phase_63),
        .control_phase_bar (seq.control_phase_bar)
    );
endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: directed frame scenarios then random rst/enable traffic.
module tb_phase_sequencer;
    import phase_seq_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clk_enable = 1'b1;

    int checks = 0;
    int errors = 0;
    int model_count = 0;
    int p63_pulses = 0;
    logic prev_p63 = 1'b0;

    phase_sequencer_if #(.COUNT_W(COUNT_W)) seq_if ();
    assign seq_if.clk_enable = clk_enable;

    phase_sequencer #(.COUNT_W(COUNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .seq (seq_if)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Expected outputs derived from the frame model: count is model_count mod 64.
    task automatic check_all(input string tag);
        logic exp_p0;
        logic exp_p63;
        exp_p0  = clk_enable && (model_count == 0);
        exp_p63 = clk_enable && (model_count == 63);
        check_eq({tag, "_count"}, 32'(seq_if.current_count), 32'(model_count));
        check_eq({tag, "_p0"},    32'(seq_if.phase_0), 32'(exp_p0));
        check_eq({tag, "_p63"},   32'(seq_if.phase_63), 32'(exp_p63));
        check_eq({tag, "_cpb"},   32'(seq_if.control_phase_bar), 32'(!exp_p0));
    endtask

    // Apply inputs, check the combinational view, clock once, check the result.
    task automatic cycle(input logic r, input logic e, input string tag);
        rst = r;
        clk_enable = e;
        #1;
        check_all({tag, "_pre"});
        @(posedge clk);
        if (r) model_count = 0;
        else if (e) model_count = (model_count + 1) % 64;
        #1;
        check_all({tag, "_post"});
        if (seq_if.phase_63 === 1'b1) p63_pulses++;
        if (prev_p63 === 1'b1) check_eq("wrap_follow_p0", 32'(seq_if.phase_0), 32'(clk_enable));
        prev_p63 = seq_if.phase_63;
    endtask

    initial begin
        @(posedge clk);
        #1;
        model_count = 0;

        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, "reset");

        for (int i = 0; i < 100; i++) begin
            cycle(1'b0, 1'b1, "run");
            if (i == 0)  check_eq("edge1_count", 32'(seq_if.current_count), 32'd1);
            if (i == 62) check_eq("edge63_p63", 32'(seq_if.phase_63), 32'd1);
            if (i == 63) check_eq("edge64_p0", 32'(seq_if.phase_0), 32'd1);
        end
        check_eq("edge100_count", 32'(seq_if.current_count), 32'd36);

        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, "midrst");
        check_eq("midrst_count", 32'(seq_if.current_count), 32'd0);

        p63_pulses = 0;
        prev_p63 = 1'b0;
        for (int i = 0; i < 200; i++) cycle(1'b0, 1'b1, "run200");
        check_eq("run200_p63_pulses", 32'(p63_pulses), 32'd3);
        check_eq("edge200_count", 32'(seq_if.current_count), 32'd8);

        cycle(1'b0, 1'b1, "to10");
        cycle(1'b0, 1'b1, "to10");
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, "gate10");
        check_eq("gate10_hold", 32'(seq_if.current_count), 32'd10);
        cycle(1'b0, 1'b1, "reen10");
        check_eq("reen10_count", 32'(seq_if.current_count), 32'd11);

        for (int i = 0; i < 52; i++) cycle(1'b0, 1'b1, "to63");
        check_eq("at63_p63", 32'(seq_if.phase_63), 32'd1);
        cycle(1'b0, 1'b0, "gate63");
        cycle(1'b0, 1'b0, "gate63");
        check_eq("gate63_hold", 32'(seq_if.current_count), 32'd63);
        cycle(1'b0, 1'b1, "reen63");
        check_eq("reen63_wrap", 32'(seq_if.current_count), 32'd0);
        cycle(1'b0, 1'b0, "gate0");
        check_eq("gate0_cpb", 32'(seq_if.control_phase_bar), 32'd1);

        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
